// File: rtl/sap_ctrl_seq.sv
// SAP-1 control sequencer: six-state one-hot ring (fetch T1-T3, execute T4-T6) driving register-file strobes.
// Latency: strobes are Moore-decoded from the current ring state and opcode, and act on the next rising edge.
// Backpressure: none; the ring advances every clock until HLT, then holds until reset.
module sap_ctrl_seq #(
    parameter bit         EARLY_END = 1'b0,
    parameter logic [3:0] OPC_LDA   = 4'h0,
    parameter logic [3:0] OPC_ADD   = 4'h1,
    parameter logic [3:0] OPC_SUB   = 4'h2,
    parameter logic [3:0] OPC_OUT   = 4'hE,
    parameter logic [3:0] OPC_HLT   = 4'hF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       b_in,
    output logic       acc_in,
    output logic       acc_out,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       out_in,
    output logic       halt
);

    // Encodings double as the visible ring value; the halted state reads as all zeros.
    typedef enum logic [5:0] {
        ST_HALT = 6'b000000,
        ST_T1   = 6'b000001,
        ST_T2   = 6'b000010,
        ST_T3   = 6'b000100,
        ST_T4   = 6'b001000,
        ST_T5   = 6'b010000,
        ST_T6   = 6'b100000
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   halted;
    logic   halted_nxt;

    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;
    logic is_alu;

    assign is_lda  = (opcode == OPC_LDA);
    assign is_add  = (opcode == OPC_ADD);
    assign is_sub  = (opcode == OPC_SUB);
    assign is_out  = (opcode == OPC_OUT);
    assign is_hlt  = (opcode == OPC_HLT);
    assign is_alu  = is_add | is_sub;

    assign t_state = state;
    assign halt    = halted;

    // Ring and halt flag registers; synchronous reset restarts the ring at T1.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_T1;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= halted_nxt;
        end
    end

    // Next-state and strobe decode from ring position and the live opcode nibble.
    always_comb begin
        state_nxt  = state;
        halted_nxt = halted;
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        mar_in     = 1'b0;
        ram_out    = 1'b0;
        ir_in      = 1'b0;
        ir_out     = 1'b0;
        b_in       = 1'b0;
        acc_in     = 1'b0;
        acc_out    = 1'b0;
        alu_sub    = 1'b0;
        alu_out    = 1'b0;
        out_in     = 1'b0;
        case (state)
            ST_T1: begin
                pc_out    = 1'b1;
                mar_in    = 1'b1;
                state_nxt = ST_T2;
            end
            ST_T2: begin
                pc_inc    = 1'b1;
                state_nxt = ST_T3;
            end
            ST_T3: begin
                ram_out   = 1'b1;
                ir_in     = 1'b1;
                state_nxt = ST_T4;
            end
            ST_T4: begin
                state_nxt = ST_T5;
                if (is_lda || is_alu) begin
                    ir_out = 1'b1;
                    mar_in = 1'b1;
                end else if (is_out) begin
                    acc_out = 1'b1;
                    out_in  = 1'b1;
                    if (EARLY_END) state_nxt = ST_T1;
                end else if (is_hlt) begin
                    state_nxt  = ST_HALT;
                    halted_nxt = 1'b1;
                end else begin
                    // Unknown opcode: idle through execute, or skip it entirely when ending early.
                    if (EARLY_END) state_nxt = ST_T1;
                end
            end
            ST_T5: begin
                state_nxt = ST_T6;
                if (is_lda) begin
                    ram_out = 1'b1;
                    acc_in  = 1'b1;
                    if (EARLY_END) state_nxt = ST_T1;
                end else if (is_alu) begin
                    ram_out = 1'b1;
                    b_in    = 1'b1;
                    alu_sub = is_sub;
                end
            end
            ST_T6: begin
                state_nxt = ST_T1;
                if (is_alu) begin
                    alu_out = 1'b1;
                    acc_in  = 1'b1;
                    alu_sub = is_sub;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_T1;
            end
        endcase
    end

endmodule
